sprite_scheduler: RTL and testbench

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

---
 rtl/sprite_scheduler_if.sv | 38 +++
 rtl/sprite_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_scheduler_if.sv
// Bus bundle between the frame/table-write master, the graphics engine and the
// sprite scheduler: shadow-table writes, frame counter, sprite issue handshake, status.
interface sprite_scheduler_if #(
    parameter int MAX_SPRITES   = 16,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int NUM_FRAMES    = 18
);
    logic [5:0]                           frame_count;
    logic                                 wr_en;
    logic [$clog2(MAX_SPRITES)-1:0]       wr_slot;
    logic                                 wr_active;
    logic [$clog2(CANVAS_WIDTH)-1:0]      wr_x;
    logic [$clog2(CANVAS_HEIGHT)-1:0]     wr_y;
    logic [$clog2(NUM_FRAMES)-1:0]        wr_frame;
    logic                                 sprite_ready;
    logic                                 sprite_valid;
    logic [$clog2(CANVAS_WIDTH)-1:0]      sprite_x;
    logic [$clog2(CANVAS_HEIGHT)-1:0]     sprite_y;
    logic [$clog2(NUM_FRAMES)-1:0]        sprite_frame_number;
    logic                                 busy;
    logic                                 frame_done;
    logic                                 overrun;
    logic                                 accept_err;
    logic [$clog2(MAX_SPRITES+1)-1:0]     sprites_drawn;

    modport master (
        output frame_count, wr_en, wr_slot, wr_active, wr_x, wr_y, wr_frame, sprite_ready,
        input  sprite_valid, sprite_x, sprite_y, sprite_frame_number,
        input  busy, frame_done, overrun, accept_err, sprites_drawn
    );

    modport slave (
        input  frame_count, wr_en, wr_slot, wr_active, wr_x, wr_y, wr_frame, sprite_ready,
        output sprite_valid, sprite_x, sprite_y, sprite_frame_number,
        output busy, frame_done, overrun, accept_err, sprites_drawn
    );
endinterface

// File: rtl/sprite_scheduler.sv
// Double-buffered sprite table with a per-frame scanner that issues drawable
// sprites to the graphics engine in ascending slot (painter's) order.
module sprite_scheduler #(
    parameter int MAX_SPRITES   = 16,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720,
    parameter int NUM_FRAMES    = 18
) (
    input  logic              clk_pixel,
    input  logic              sys_rst,
    sprite_scheduler_if.slave bus
);
    localparam int SW      = $clog2(MAX_SPRITES);
    localparam int XW      = $clog2(CANVAS_WIDTH);
    localparam int YW      = $clog2(CANVAS_HEIGHT);
    localparam int FW      = $clog2(NUM_FRAMES);
    localparam int DW      = $clog2(MAX_SPRITES + 1);
    localparam int TIMEOUT = 4;
    localparam int TW      = $clog2(TIMEOUT);

    localparam logic [SW-1:0] LAST_SLOT = SW'(MAX_SPRITES - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT_ACCEPT, WAIT_DONE} state_e;

    typedef struct packed {
        logic          active;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [FW-1:0] frame;
    } entry_t;

    state_e        state_q, state_d;
    entry_t        shadow_q [MAX_SPRITES];
    entry_t        shadow_d [MAX_SPRITES];
    entry_t        live_q   [MAX_SPRITES];
    entry_t        live_d   [MAX_SPRITES];
    logic [5:0]    prev_frame_count_q, prev_frame_count_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [DW-1:0] drawn_q, drawn_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          sprite_valid_q, sprite_valid_d;
    logic [XW-1:0] sprite_x_q, sprite_x_d;
    logic [YW-1:0] sprite_y_q, sprite_y_d;
    logic [FW-1:0] sprite_frame_q, sprite_frame_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;
    logic          accept_err_q, accept_err_d;

    entry_t cur;
    logic   frame_edge;
    logic   drawable;
    logic   last_slot;
    logic   issue;
    logic   accepted;
    logic   timeout;
    logic   skip;
    logic   done;
    logic   advance;

    // A frame edge overrides every other event in the cycle it is seen.
    assign frame_edge = (bus.frame_count != prev_frame_count_q);
    assign cur        = live_q[slot_q];
    assign drawable   = cur.active
                     && (int'(cur.x) < CANVAS_WIDTH)
                     && (int'(cur.y) < CANVAS_HEIGHT);
    assign last_slot  = (slot_q == LAST_SLOT);
    assign issue      = !frame_edge && (state_q == SCAN) && drawable && bus.sprite_ready;
    assign skip       = !frame_edge && (state_q == SCAN) && !drawable;
    assign accepted   = !frame_edge && (state_q == WAIT_ACCEPT) && !bus.sprite_ready;
    assign timeout    = !frame_edge && (state_q == WAIT_ACCEPT) && bus.sprite_ready
                     && (timer_q == LAST_TICK);
    assign done       = !frame_edge && (state_q == WAIT_DONE) && bus.sprite_ready;
    assign advance    = skip || timeout || done;

    // Table update: commit copies the pre-write shadow, so a same-cycle write waits a frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        shadow_d = shadow_q;
        live_d   = live_q;
        if (frame_edge) begin
            live_d = shadow_q;
        end
        if (bus.wr_en) begin
            shadow_d[bus.wr_slot] = '{active: bus.wr_active, x: bus.wr_x,
                                      y: bus.wr_y, frame: bus.wr_frame};
        end
    end

    always_ff @(posedge clk_pixel) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_edge) begin
            state_d = SCAN;
        end else if (advance) begin
            state_d = last_slot ? IDLE : SCAN;
        end else if (issue) begin
            state_d = WAIT_ACCEPT;
        end else if (accepted) begin
            state_d = WAIT_DONE;
        end
    end

    always_comb begin
        prev_frame_count_d = bus.frame_count;
        slot_d             = slot_q;
        drawn_d            = drawn_q;
        timer_d            = '0;
        sprite_valid_d     = 1'b0;
        sprite_x_d         = sprite_x_q;
        sprite_y_d         = sprite_y_q;
        sprite_frame_d     = sprite_frame_q;
        frame_done_d       = 1'b0;
        overrun_d          = 1'b0;
        accept_err_d       = 1'b0;

        if (frame_edge) begin
            slot_d    = '0;
            drawn_d   = '0;
            overrun_d = (state_q != IDLE);
        end else begin
            if (issue) begin
                sprite_valid_d = 1'b1;
                sprite_x_d     = cur.x;
                sprite_y_d     = cur.y;
                sprite_frame_d = cur.frame;
            end
            if ((state_q == WAIT_ACCEPT) && bus.sprite_ready && !timeout) begin
                timer_d = timer_q + TW'(1);
            end
            accept_err_d = timeout;
            if (done) begin
                drawn_d = drawn_q + DW'(1);
            end
            if (advance) begin
                if (last_slot) begin
                    frame_done_d = 1'b1;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
        end
    end

    assign bus.busy                = (state_q != IDLE);
    assign bus.sprite_valid        = sprite_valid_q;
    assign bus.sprite_x            = sprite_x_q;
    assign bus.sprite_y            = sprite_y_q;
    assign bus.sprite_frame_number = sprite_frame_q;
    assign bus.frame_done          = frame_done_q;
    assign bus.overrun             = overrun_q;
    assign bus.accept_err          = accept_err_q;
    assign bus.sprites_drawn       = drawn_q;

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            prev_frame_count_q <= bus.frame_count;
            slot_q             <= '0;
            drawn_q            <= '0;
            timer_q            <= '0;
            sprite_valid_q     <= 1'b0;
            sprite_x_q         <= '0;
            sprite_y_q         <= '0;
            sprite_frame_q     <= '0;
            frame_done_q       <= 1'b0;
            overrun_q          <= 1'b0;
            accept_err_q       <= 1'b0;
            // NOTE: only the active bits of the tables are reset; coordinates are don't-care until written.
            for (int i = 0; i < MAX_SPRITES; i++) begin
                shadow_q[i].active <= 1'b0;
                live_q[i].active   <= 1'b0;
            end
        end else begin
            prev_frame_count_q <= prev_frame_count_d;
            slot_q             <= slot_d;
            drawn_q            <= drawn_d;
            timer_q            <= timer_d;
            sprite_valid_q     <= sprite_valid_d;
            sprite_x_q         <= sprite_x_d;
            sprite_y_q         <= sprite_y_d;
            sprite_frame_q     <= sprite_frame_d;
            frame_done_q       <= frame_done_d;
            overrun_q          <= overrun_d;
            accept_err_q       <= accept_err_d;
            shadow_q           <= shadow_d;
            live_q             <= live_d;
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: scan order, skip, overrun, accept timeout,
// shadow/live double buffering and mid-frame reset.
module tb_sprite_scheduler;
    logic clk_pixel;
    logic sys_rst;

    sprite_scheduler_if #(.MAX_SPRITES(16), .CANVAS_WIDTH(360),
                          .CANVAS_HEIGHT(720), .NUM_FRAMES(18)) bus ();

    sprite_scheduler #(.MAX_SPRITES(16), .CANVAS_WIDTH(360),
                       .CANVAS_HEIGHT(720), .NUM_FRAMES(18)) dut (
        .clk_pixel (clk_pixel),
        .sys_rst   (sys_rst),
        .bus       (bus)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int checks   = 0;
    int failures = 0;
    int iss_x[$];
    int iss_y[$];
    int iss_f[$];
    int fd_cnt, ov_cnt, ae_cnt;
    int b2b_cnt  = 0;
    logic prev_valid = 1'b0;
    logic gfx_auto   = 1'b0;
    int gfx_busy     = 4096;
    int busy_left    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: outputs sampled on the falling edge, graphics model reacts there too.
    task automatic step();
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        if (bus.sprite_valid) begin
            iss_x.push_back(int'(bus.sprite_x));
            iss_y.push_back(int'(bus.sprite_y));
            iss_f.push_back(int'(bus.sprite_frame_number));
            if (prev_valid) b2b_cnt++;
        end
        prev_valid = bus.sprite_valid;
        if (bus.frame_done) fd_cnt++;
        if (bus.overrun) ov_cnt++;
        if (bus.accept_err) ae_cnt++;
        if (gfx_auto) begin
            if (bus.sprite_valid) begin
                bus.sprite_ready = 1'b0;
                busy_left = gfx_busy;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.sprite_ready = 1'b1;
            end
        end
    endtask

    task automatic clear_stats();
        iss_x.delete();
        iss_y.delete();
        iss_f.delete();
        fd_cnt = 0;
        ov_cnt = 0;
        ae_cnt = 0;
    endtask

    task automatic write_slot(input logic [3:0] slot, input logic act, input logic [8:0] x,
                              input logic [9:0] y, input logic [4:0] f);
        bus.wr_en     = 1'b1;
        bus.wr_slot   = slot;
        bus.wr_active = act;
        bus.wr_x      = x;
        bus.wr_y      = y;
        bus.wr_frame  = f;
        step();
        bus.wr_en     = 1'b0;
    endtask

    task automatic new_frame();
        bus.frame_count = bus.frame_count + 6'd1;
        step();
    endtask

    task automatic wait_frame_done(input int limit);
        for (int i = 0; i < limit && fd_cnt == 0; i++) step();
    endtask

    initial begin
        int n;
        sys_rst          = 1'b1;
        bus.frame_count  = 6'd0;
        bus.wr_en        = 1'b0;
        bus.wr_slot      = '0;
        bus.wr_active    = 1'b0;
        bus.wr_x         = '0;
        bus.wr_y         = '0;
        bus.wr_frame     = '0;
        bus.sprite_ready = 1'b1;
        clear_stats();

        // Reset; frame_count moves during reset and must not cause an edge on release
        step();
        bus.frame_count = 6'd5;
        step();
        step();
        check("rst_valid", int'(bus.sprite_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_accept_err", int'(bus.accept_err), 0);
        check("rst_drawn", int'(bus.sprites_drawn), 0);
        check("rst_x", int'(bus.sprite_x), 0);
        sys_rst = 1'b0;
        step();
        step();
        check("release_no_edge_busy", int'(bus.busy), 0);

        // Two sprites, slow graphics engine: slot 0 then slot 3
        write_slot(4'd0, 1'b1, 9'd10, 10'd20, 5'd2);
        write_slot(4'd3, 1'b1, 9'd100, 10'd600, 5'd5);
        clear_stats();
        gfx_auto = 1'b1;
        gfx_busy = 4096;
        new_frame();
        wait_frame_done(20000);
        for (int i = 0; i < 5; i++) step();
        check("two_issue_count", iss_x.size(), 2);
        check("two_first_x", iss_x[0], 10);
        check("two_first_y", iss_y[0], 20);
        check("two_first_f", iss_f[0], 2);
        check("two_second_x", iss_x[1], 100);
        check("two_second_y", iss_y[1], 600);
        check("two_second_f", iss_f[1], 5);
        check("two_drawn", int'(bus.sprites_drawn), 2);
        check("two_frame_done_once", fd_cnt, 1);
        check("two_idle", int'(bus.busy), 0);
        check("two_hold_x", int'(bus.sprite_x), 100);

        // Off-canvas sprite is skipped; frame_done after 16 scan cycles
        gfx_auto = 1'b0;
        bus.sprite_ready = 1'b1;
        write_slot(4'd0, 1'b0, 9'd0, 10'd0, 5'd0);
        write_slot(4'd3, 1'b0, 9'd0, 10'd0, 5'd0);
        write_slot(4'd1, 1'b1, 9'd360, 10'd5, 5'd1);
        clear_stats();
        new_frame();
        n = 0;
        while (fd_cnt == 0 && n < 100) begin
            step();
            n++;
        end
        check("skip_scan_cycles", n, 16);
        check("skip_no_issue", iss_x.size(), 0);
        check("skip_drawn", int'(bus.sprites_drawn), 0);

        // Frame edge while slot 0 is in WAIT_DONE
        write_slot(4'd1, 1'b0, 9'd0, 10'd0, 5'd0);
        write_slot(4'd0, 1'b1, 9'd10, 10'd20, 5'd2);
        clear_stats();
        new_frame();
        step();
        check("ovr_first_issue", iss_x.size(), 1);
        bus.sprite_ready = 1'b0;
        step();
        step();
        check("ovr_busy_in_wait_done", int'(bus.busy), 1);
        bus.frame_count = bus.frame_count + 6'd1;
        step();
        check("ovr_pulse", int'(bus.overrun), 1);
        check("ovr_no_frame_done", int'(bus.frame_done), 0);
        check("ovr_valid_low", int'(bus.sprite_valid), 0);
        check("ovr_drawn_cleared", int'(bus.sprites_drawn), 0);
        for (int i = 0; i < 5; i++) step();
        check("ovr_withheld", iss_x.size(), 1);
        check("ovr_single_pulse", ov_cnt, 1);
        bus.sprite_ready = 1'b1;
        step();
        check("ovr_reissue", iss_x.size(), 2);
        check("ovr_reissue_x", iss_x[1], 10);
        bus.sprite_ready = 1'b0;
        step();
        bus.sprite_ready = 1'b1;
        step();
        wait_frame_done(100);
        check("ovr_frame_done", fd_cnt, 1);
        check("ovr_drawn", int'(bus.sprites_drawn), 1);

        // Graphics never drops ready: timeout after 4 WAIT_ACCEPT cycles
        write_slot(4'd1, 1'b1, 9'd50, 10'd60, 5'd7);
        clear_stats();
        new_frame();
        step();
        check("to_issue", int'(bus.sprite_valid), 1);
        step();
        step();
        step();
        check("to_not_early", ae_cnt, 0);
        step();
        check("to_accept_err", int'(bus.accept_err), 1);
        step();
        check("to_next_slot_valid", int'(bus.sprite_valid), 1);
        check("to_next_slot_x", iss_x[1], 50);
        wait_frame_done(100);
        check("to_err_count", ae_cnt, 2);
        check("to_drawn", int'(bus.sprites_drawn), 0);

        // Mid-frame shadow write lands next frame only
        write_slot(4'd1, 1'b0, 9'd0, 10'd0, 5'd0);
        gfx_auto = 1'b1;
        gfx_busy = 4;
        clear_stats();
        new_frame();
        step();
        write_slot(4'd2, 1'b1, 9'd200, 10'd300, 5'd9);
        wait_frame_done(200);
        check("shadow_cur_issues", iss_x.size(), 1);
        check("shadow_cur_drawn", int'(bus.sprites_drawn), 1);
        clear_stats();
        new_frame();
        wait_frame_done(200);
        check("shadow_next_issues", iss_x.size(), 2);
        check("shadow_next_x", iss_x[1], 200);
        check("shadow_next_y", iss_y[1], 300);
        check("shadow_next_f", iss_f[1], 9);
        check("shadow_next_drawn", int'(bus.sprites_drawn), 2);

        // Reset while in WAIT_DONE
        gfx_auto = 1'b0;
        bus.sprite_ready = 1'b1;
        clear_stats();
        new_frame();
        step();
        bus.sprite_ready = 1'b0;
        step();
        step();
        sys_rst = 1'b1;
        step();
        check("mrst_valid", int'(bus.sprite_valid), 0);
        check("mrst_busy", int'(bus.busy), 0);
        check("mrst_x", int'(bus.sprite_x), 0);
        check("mrst_y", int'(bus.sprite_y), 0);
        check("mrst_f", int'(bus.sprite_frame_number), 0);
        check("mrst_drawn", int'(bus.sprites_drawn), 0);
        bus.frame_count = bus.frame_count + 6'd3;
        step();
        sys_rst = 1'b0;
        bus.sprite_ready = 1'b1;
        step();
        step();
        step();
        check("mrst_idle", int'(bus.busy), 0);
        check("mrst_no_frame_done", fd_cnt, 0);
        check("mrst_no_overrun", ov_cnt, 0);
        check("mrst_no_accept_err", ae_cnt, 0);
        check("mrst_no_new_issue", iss_x.size(), 1);

        check("valid_never_back_to_back", b2b_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
